// File: rtl/mul_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = the EX-stage side driving operands and taking the product,
// slave  = the multiplier controller.
interface mul_seq_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  modport master (
    output flush, in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  flush, in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier sharing one 32-bit
// carry-select adder across 32 iterations.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for operands (in_ready=1)
// RUN   | one shift-add iteration per cycle, cnt counts 0..31
// DONE  | product presented (out_valid=1) until out_ready

// 32-bit carry-select adder built from 4-bit blocks.
module carryselectadder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign s1 = s0 + 5'd1;
    assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
    assign c[g+1] = c[g] ? s1[4] : s0[4];
  end

  assign cout = c[8];
endmodule

module mul_seq_ctrl #(
  parameter bit BYPASS_TRIVIAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;

  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_c;
  logic        unused_cout;
  logic        trivial;

  assign trivial = BYPASS_TRIVIAL && ((bus.op_a == 32'd0) || (bus.op_b == 32'd0));

  assign add_b = acc_lo[0] ? mcand : 32'd0;

  // The adder's own carry-out is left unused; the carry into acc_hi[31]
  // is rebuilt from the operand and sum MSBs.
  carryselectadder32bit u_add (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  assign add_c = (acc_hi[31] & add_b[31]) | ((acc_hi[31] ^ add_b[31]) & ~add_sum[31]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; flush wins over accept and over completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!bus.flush && bus.in_valid) state_nxt = RUN;
      RUN: begin
        if (bus.flush)           state_nxt = IDLE;
        else if (cnt == 5'd31)   state_nxt = DONE;
      end
      DONE: begin
        if (bus.flush || bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load and shift-add datapath. A trivial (zero) operand enters
  // RUN with zeroed accumulators and cnt preset to 31, so a single
  // iteration of adding zero lands in DONE one edge after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      cnt    <= 5'd0;
    end else if (bus.flush) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.op_a;
            acc_hi <= 32'd0;
            if (trivial) begin
              acc_lo <= 32'd0;
              cnt    <= 5'd31;
            end else begin
              acc_lo <= bus.op_b;
              cnt    <= 5'd0;
            end
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= {add_c, add_sum, acc_lo[31:1]};
          cnt              <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = {acc_hi, acc_lo};
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one instance with the zero-operand
// bypass enabled and one with it disabled.
module tb_mul_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mul_seq_ctrl_if bi ();
  mul_seq_ctrl_if bn ();

  mul_seq_ctrl #(.BYPASS_TRIVIAL(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bi));
  mul_seq_ctrl #(.BYPASS_TRIVIAL(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(bn));

  always #5 clk = ~clk;

  // Accept one operation on the bypass instance, then count edges until
  // out_valid is seen (100 means it never came).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    bi.op_a = a;
    bi.op_b = b;
    bi.in_valid = 1'b1;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    lat = 0;
    while (!bi.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int k;
    bi.in_valid = 1'b0;
    bi.out_ready = 1'b1;
    k = 0;
    while (!bi.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bi.flush = 0; bi.in_valid = 0; bi.op_a = 0; bi.op_b = 0; bi.out_ready = 0;
    bn.flush = 0; bn.in_valid = 0; bn.op_a = 0; bn.op_b = 0; bn.out_ready = 0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bi.in_ready); end
    n_vec++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bi.out_valid); end
    n_vec++; if (bi.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bi.busy); end
    n_vec++; if (bi.product !== 64'd0) begin n_err++; $display("FAIL reset_product got %h exp 0", bi.product); end
  endtask

  task automatic test_basic();
    int lat;
    bi.out_ready = 1'b1;
    do_op(32'd7, 32'd6, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL basic_latency got %0d exp 32", lat); end
    n_vec++; if (bi.product !== 64'h0000_0000_0000_002A) begin n_err++; $display("FAIL basic_product got %h exp 2a", bi.product); end
    n_vec++; if (bi.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done got %b exp 1", bi.busy); end
    n_vec++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done got %b exp 0", bi.in_ready); end
    @(posedge clk); #1;
    n_vec++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after got %b exp 1", bi.in_ready); end
    n_vec++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_after got %b exp 0", bi.out_valid); end
  endtask

  task automatic test_carry();
    int lat;
    bi.out_ready = 1'b1;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL carry_latency got %0d exp 32", lat); end
    n_vec++; if (bi.product !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL carry_product got %h exp fffffffe00000001", bi.product); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    int lat;
    bi.out_ready = 1'b1;
    do_op(32'h8000_0000, 32'd0, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL bypass_b0_latency got %0d exp 1", lat); end
    n_vec++; if (bi.product !== 64'd0) begin n_err++; $display("FAIL bypass_b0_product got %h exp 0", bi.product); end
    @(posedge clk); #1;
    do_op(32'd0, 32'd5, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL bypass_a0_latency got %0d exp 1", lat); end
    n_vec++; if (bi.product !== 64'd0) begin n_err++; $display("FAIL bypass_a0_product got %h exp 0", bi.product); end
    @(posedge clk); #1;
    bn.out_ready = 1'b1;
    bn.op_a = 32'h8000_0000;
    bn.op_b = 32'd0;
    bn.in_valid = 1'b1;
    @(posedge clk); #1;
    bn.in_valid = 1'b0;
    lat = 0;
    while (!bn.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL nobypass_latency got %0d exp 32", lat); end
    n_vec++; if (bn.product !== 64'd0) begin n_err++; $display("FAIL nobypass_product got %h exp 0", bn.product); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int lat;
    logic [63:0] exp_p;
    exp_p = 64'h0B00_EA4E_242D_2080;
    bi.out_ready = 1'b0;
    do_op(32'h1234_5678, 32'h9ABC_DEF0, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL stall_latency got %0d exp 32", lat); end
    n_vec++; if (bi.product !== exp_p) begin n_err++; $display("FAIL stall_product got %h exp %h", bi.product, exp_p); end
    for (int i = 0; i < 10; i++) begin
      bi.in_valid = i[0];
      bi.op_a = 32'd3 + i;
      bi.op_b = 32'd11;
      @(posedge clk); #1;
      n_vec++; if (bi.product !== exp_p) begin n_err++; $display("FAIL stall_hold_product cyc %0d got %h exp %h", i, bi.product, exp_p); end
      n_vec++; if (bi.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid cyc %0d got %b exp 1", i, bi.out_valid); end
      n_vec++; if (bi.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", i, bi.in_ready); end
    end
    bi.in_valid = 1'b0;
    bi.out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b exp 1", bi.in_ready); end
    n_vec++; if (bi.busy !== 1'b0) begin n_err++; $display("FAIL stall_release_busy got %b exp 0", bi.busy); end
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    bi.out_ready = 1'b1;
    bi.op_a = 32'h1234;
    bi.op_b = 32'h5678;
    bi.in_valid = 1'b1;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (bi.busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_before got %b exp 1", bi.busy); end
    bi.flush = 1'b1;
    @(posedge clk); #1;
    bi.flush = 1'b0;
    n_vec++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b exp 1", bi.in_ready); end
    n_vec++; if (bi.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b exp 0", bi.busy); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bi.out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_out_valid_seen got %b exp 0", seen); end
    bi.op_a = 32'd3;
    bi.op_b = 32'd5;
    bi.in_valid = 1'b1;
    bi.flush = 1'b1;
    @(posedge clk); #1;
    bi.flush = 1'b0;
    bi.in_valid = 1'b0;
    n_vec++; if (bi.busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept_busy got %b exp 0", bi.busy); end
    do_op(32'd3, 32'd5, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL flush_next_latency got %0d exp 32", lat); end
    n_vec++; if (bi.product !== 64'd15) begin n_err++; $display("FAIL flush_next_product got %h exp f", bi.product); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bi.out_ready = 1'b1;
    bi.op_a = 32'h0000_FFFF;
    bi.op_b = 32'h0001_0001;
    bi.in_valid = 1'b1;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++; if (bi.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", bi.busy); end
    n_vec++; if (bi.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b exp 1", bi.in_ready); end
    n_vec++; if (bi.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b exp 0", bi.out_valid); end
    n_vec++; if (bi.product !== 64'd0) begin n_err++; $display("FAIL rstmid_product got %h exp 0", bi.product); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'h0000_FFFF, 32'h0001_0001, lat);
    n_vec++; if (lat !== 32) begin n_err++; $display("FAIL rstmid_next_latency got %0d exp 32", lat); end
    n_vec++; if (bi.product !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL rstmid_next_product got %h exp ffffffff", bi.product); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_edges[$];
    int gap;
    bi.out_ready = 1'b1;
    bi.op_a = 32'd0;
    bi.op_b = 32'd9;
    bi.in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bi.in_ready) acc_edges.push_back(k);
      @(posedge clk); #1;
    end
    drain();
    gap = (acc_edges.size() >= 2) ? acc_edges[1] - acc_edges[0] : -1;
    n_vec++; if (gap !== 3) begin n_err++; $display("FAIL b2b_bypass_spacing got %0d exp 3", gap); end
    acc_edges.delete();
    bi.op_a = 32'd3;
    bi.op_b = 32'd5;
    bi.in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (bi.in_ready) acc_edges.push_back(k);
      @(posedge clk); #1;
    end
    drain();
    gap = (acc_edges.size() >= 2) ? acc_edges[1] - acc_edges[0] : -1;
    n_vec++; if (gap !== 34) begin n_err++; $display("FAIL b2b_normal_spacing got %0d exp 34", gap); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_bypass();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
